// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch slice.
package fetch_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned INSN_BYTES = 4;
    localparam logic [31:0] NOP_INST   = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} entries; flush has priority.
module fetch_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Empty FIFO presents zeros rather than a stale entry.
    assign o_head  = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch initiator: owns the PC, drives the combinational ROM, buffers words for decode
// and handles redirects (including misaligned targets) from execute.
module inst_fetch_unit #(
    parameter int unsigned          ADDR_W   = fetch_pkg::ADDR_W,
    parameter int unsigned          DATA_W   = fetch_pkg::DATA_W,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter int unsigned          DEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_en,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic [DATA_W-1:0]    imem_data,
    input  logic                 redirect_valid,
    input  logic [ADDR_W-1:0]    redirect_pc,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [DATA_W-1:0]    if_inst,
    output logic [ADDR_W-1:0]    if_pc,
    output logic                 misalign_err
);

    import fetch_pkg::*;

    localparam int unsigned       CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    fetch_state_t               r_state;
    fetch_state_t               w_state_nxt;
    logic [ADDR_W-1:0]          r_pc;
    logic                       r_misalign;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_redirect_bad;
    logic [CNT_W-1:0]           w_count;
    logic [ADDR_W+DATA_W-1:0]   w_head;

    assign w_redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A redirect overrides the current state; only an aligned one leaves ERR.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            if (w_redirect_bad) begin
                w_state_nxt = ERR;
            end else begin
                w_state_nxt = fetch_en ? RUN : IDLE;
            end
        end else begin
            case (r_state)
                IDLE:    if (fetch_en)  w_state_nxt = RUN;
                RUN:     if (!fetch_en) w_state_nxt = IDLE;
                ERR:     w_state_nxt = ERR;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_pop  = if_valid && if_ready;
        w_push = (r_state == RUN) && fetch_en && !redirect_valid &&
                 ((w_count < FULL_CNT) || w_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + ADDR_W'(INSN_BYTES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid) begin
            r_misalign <= w_redirect_bad;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  ({r_pc, imem_data}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign imem_addr     = r_pc;
    assign if_valid      = (w_count != '0);
    assign if_pc         = w_head[ADDR_W+DATA_W-1:DATA_W];
    assign if_inst       = w_head[DATA_W-1:0];
    assign misalign_err  = r_misalign;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: stimulus queues expected {pc, inst} words,
// a negedge monitor compares every decode handshake against the queue.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [7:0]  if_pc;
    logic        misalign_err;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_q [$];
    logic [39:0] mon_exp;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .RESET_PC (8'h00),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .misalign_err   (misalign_err)
    );

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        case (a)
            8'h00:   rom_word = 32'h0ff00083;
            8'h04:   rom_word = 32'h00100113;
            8'h08:   rom_word = 32'h0020f1b3;
            default: rom_word = {24'hA00000, a};
        endcase
    endfunction

    always_comb imem_data = rom_word(imem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] pc, input logic [31:0] inst);
        exp_q.push_back({pc, inst});
    endtask

    // Handshakes in a redirect cycle are dropped by the DUT, so they are not consumed here.
    always @(negedge clk) begin
        if (rst_n && !redirect_valid && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got pc %0h inst %0h expected none", if_pc, if_inst);
            end else begin
                mon_exp = exp_q.pop_front();
                check("deliver", 64'({if_pc, if_inst}), 64'(mon_exp));
            end
        end
    end

    task automatic wait_drain(input string name);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || if_valid) && n < 40) begin
            tick();
            n++;
        end
        check({name, "_drain"}, 64'(exp_q.size() == 0 && !if_valid), 64'd1);
        exp_q.delete();
    endtask

    task automatic run_from_reset(input string name);
        push_exp(8'h00, 32'h0ff00083);
        push_exp(8'h04, 32'h00100113);
        push_exp(8'h08, 32'h0020f1b3);
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        if_ready = 1'b1;
        tick();
        tick();
        check({name, "_valid_c2"}, 64'(if_valid), 64'd1);
        tick();
        check({name, "_valid_c3"}, 64'(if_valid), 64'd1);
        tick();
        check({name, "_valid_c4"}, 64'(if_valid), 64'd1);
        check({name, "_addr_after3"}, 64'(imem_addr), 64'h0C);
        fetch_en = 1'b0;
        wait_drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        #1;
        check("rst_valid", 64'(if_valid), 64'd0);
        check("rst_inst", 64'(if_inst), 64'd0);
        check("rst_pc", 64'(if_pc), 64'd0);
        check("rst_misalign", 64'(misalign_err), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'h00);

        // 1: basic stream from reset
        tick();
        run_from_reset("t1");

        // 2: backpressure fills FIFO, PC stalls
        redirect_valid = 1'b1;
        redirect_pc    = 8'h00;
        fetch_en       = 1'b1;
        if_ready       = 1'b0;
        tick();
        redirect_valid = 1'b0;
        check("t2_flushed", 64'(if_valid), 64'd0);
        repeat (4) tick();
        check("t2_stall_addr", 64'(imem_addr), 64'h08);
        check("t2_head_pc", 64'(if_pc), 64'h00);
        check("t2_head_inst", 64'(if_inst), 64'h0ff00083);
        check("t2_valid", 64'(if_valid), 64'd1);
        push_exp(8'h00, 32'h0ff00083);
        push_exp(8'h04, 32'h00100113);
        push_exp(8'h08, 32'h0020f1b3);
        if_ready = 1'b1;
        tick();
        fetch_en = 1'b0;
        wait_drain("t2");

        // 3: redirect while full with a pop in the same cycle
        redirect_valid = 1'b1;
        redirect_pc    = 8'h20;
        fetch_en       = 1'b1;
        if_ready       = 1'b0;
        tick();
        redirect_valid = 1'b0;
        repeat (3) tick();
        check("t3_full_head", 64'(if_pc), 64'h20);
        check("t3_full_addr", 64'(imem_addr), 64'h28);
        push_exp(8'h00, 32'h0ff00083);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h00;
        if_ready       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("t3_dropped", 64'(if_valid), 64'd0);
        tick();
        check("t3_pc", 64'(if_pc), 64'h00);
        check("t3_inst", 64'(if_inst), 64'h0ff00083);
        fetch_en = 1'b0;
        wait_drain("t3");

        // 4: PC wrap from FC
        push_exp(8'hFC, 32'hA00000FC);
        push_exp(8'h00, 32'h0ff00083);
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFC;
        fetch_en       = 1'b1;
        if_ready       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        check("t4_wrap_addr", 64'(imem_addr), 64'h04);
        check("t4_misalign", 64'(misalign_err), 64'd0);
        fetch_en = 1'b0;
        wait_drain("t4");

        // 5: misaligned redirect parks in ERR until an aligned one
        redirect_valid = 1'b1;
        redirect_pc    = 8'h06;
        fetch_en       = 1'b1;
        if_ready       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("t5_misalign_set", 64'(misalign_err), 64'd1);
        check("t5_addr", 64'(imem_addr), 64'h06);
        check("t5_valid", 64'(if_valid), 64'd0);
        bad = 0;
        repeat (10) begin
            tick();
            if (if_valid || imem_addr != 8'h06) bad++;
        end
        check("t5_no_push", 64'(bad), 64'd0);
        push_exp(8'h10, 32'hA0000010);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h10;
        tick();
        redirect_valid = 1'b0;
        check("t5_misalign_clr", 64'(misalign_err), 64'd0);
        tick();
        check("t5_resume_pc", 64'(if_pc), 64'h10);
        fetch_en = 1'b0;
        wait_drain("t5");

        // 6: asynchronous reset mid-stream
        push_exp(8'h00, 32'h0ff00083);
        push_exp(8'h04, 32'h00100113);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h00;
        fetch_en       = 1'b1;
        if_ready       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_delivered", 64'(exp_q.size()), 64'd0);
        check("t6_valid", 64'(if_valid), 64'd0);
        check("t6_pc", 64'(if_pc), 64'd0);
        check("t6_inst", 64'(if_inst), 64'd0);
        check("t6_addr", 64'(imem_addr), 64'h00);
        check("t6_misalign", 64'(misalign_err), 64'd0);
        exp_q.delete();
        tick();
        run_from_reset("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
